// File: rtl/video_timing_pkg.sv
// video_timing_pkg
//   Shared types and defaults for the raster timing generator.
//   - phase_t       : per-axis blanking phase (active, front porch, sync, back porch)
//   - DEF_*         : 1920x1080 @ 60 Hz timing defaults (148.5 MHz pixel clock)
//   - axis_total()  : length of one axis period from its four phase lengths
//   - h_total() / v_total() : named wrappers used by the top level
package video_timing_pkg;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_t;

  localparam int DEF_H_ACTIVE     = 1920;
  localparam int DEF_H_FP         = 88;
  localparam int DEF_H_SYNC       = 44;
  localparam int DEF_H_BP         = 148;
  localparam int DEF_V_ACTIVE     = 1080;
  localparam int DEF_V_FP         = 4;
  localparam int DEF_V_SYNC       = 5;
  localparam int DEF_V_BP         = 36;
  localparam bit DEF_HS_POL       = 1'b1;
  localparam bit DEF_VS_POL       = 1'b1;
  localparam int DEF_PREFETCH_CYC = 64;

  function automatic int axis_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int h_total(input int act, input int fp, input int sync, input int bp);
    return axis_total(act, fp, sync, bp);
  endfunction

  function automatic int v_total(input int act, input int fp, input int sync, input int bp);
    return axis_total(act, fp, sync, bp);
  endfunction

endpackage

// File: rtl/raster_axis_cnt.sv
// raster_axis_cnt
//   One raster axis: a wrapping position counter plus its
//   ACTIVE -> FRONT -> SYNC -> BACK phase machine. Used once for the
//   horizontal axis (advances every enabled clock) and once for the
//   vertical axis (advances on each horizontal wrap).
// Ports
//   clk      in   clock, rising edge
//   reset    in   synchronous, active-low
//   i_inc    in   advance the axis by one position this clock
//   o_count  out  current position 0..TOTAL-1
//   o_last   out  position is TOTAL-1 (the axis wraps on the next increment)
//   o_sync   out  sync level for the current phase, polarity POL
//   o_active out  current phase is ACTIVE
module raster_axis_cnt
  import video_timing_pkg::*;
#(
  parameter int ACTIVE = 8,
  parameter int FP     = 2,
  parameter int SYNC   = 2,
  parameter int BP     = 2,
  parameter bit POL    = 1'b1,
  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP),
  localparam int CW    = $clog2(TOTAL)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_inc,
  output logic [CW-1:0] o_count,
  output logic          o_last,
  output logic          o_sync,
  output logic          o_active
);

  // Last position of each phase; the phase changes when the counter leaves it.
  localparam logic [CW-1:0] LAST_ACT   = CW'(ACTIVE - 1);
  localparam logic [CW-1:0] LAST_FRONT = CW'(ACTIVE + FP - 1);
  localparam logic [CW-1:0] LAST_SYNC  = CW'(ACTIVE + FP + SYNC - 1);
  localparam logic [CW-1:0] LAST_POS   = CW'(TOTAL - 1);

  logic [CW-1:0] r_count;
  phase_t        r_phase;
  phase_t        w_phase_next;
  logic          w_wrap;

  assign o_count = r_count;
  assign o_last  = (r_count == LAST_POS);
  assign w_wrap  = i_inc & o_last;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= w_wrap ? '0 : r_count + CW'(1);
    end
  end

  // Phase machine: state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_phase <= PH_ACTIVE;
    end else begin
      r_phase <= w_phase_next;
    end
  end

  // Phase machine: next state, evaluated at the counter boundaries
  always_comb begin
    w_phase_next = r_phase;
    if (i_inc) begin
      case (r_phase)
        PH_ACTIVE: if (r_count == LAST_ACT)   w_phase_next = PH_FRONT;
        PH_FRONT:  if (r_count == LAST_FRONT) w_phase_next = PH_SYNC;
        PH_SYNC:   if (r_count == LAST_SYNC)  w_phase_next = PH_BACK;
        PH_BACK:   if (r_count == LAST_POS)   w_phase_next = PH_ACTIVE;
        default:   w_phase_next = PH_ACTIVE;
      endcase
    end
  end

  // Phase machine: outputs
  always_comb begin
    o_sync   = ~POL;
    o_active = 1'b0;
    case (r_phase)
      PH_ACTIVE: o_active = 1'b1;
      PH_SYNC:   o_sync   = POL;
      default:   ;
    endcase
  end

endmodule

// File: rtl/scan_timing_ctrl.sv
// scan_timing_ctrl
//   Master raster sequencer for the scanout path. Runs the horizontal and
//   vertical axes, registers pixel coordinates / syncs / frame marker, and
//   issues one line-fetch request per active line with an underrun flag
//   when the fetch is still outstanding as its line begins.
// Ports
//   clk          in   pixel clock, rising edge
//   reset        in   synchronous, active-low
//   enable       in   1 = advance raster, 0 = hold all state
//   x, y         out  active pixel column / row, 0 outside the active area
//   active       out  inside the active area
//   hsync/vsync  out  sync strobes, polarity HS_POL / VS_POL
//   frame_start  out  one-clock marker for hc=0, vc=0
//   line_req     out  fetch request for row line_req_y
//   line_req_y   out  row to fetch, stable while line_req=1
//   line_ack     in   reader accepted the pending request
//   underrun     out  one-clock pulse: line began with its fetch unacknowledged
module scan_timing_ctrl
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int H_FP         = DEF_H_FP,
  parameter int H_SYNC       = DEF_H_SYNC,
  parameter int H_BP         = DEF_H_BP,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int V_FP         = DEF_V_FP,
  parameter int V_SYNC       = DEF_V_SYNC,
  parameter int V_BP         = DEF_V_BP,
  parameter bit HS_POL       = DEF_HS_POL,
  parameter bit VS_POL       = DEF_VS_POL,
  parameter int PREFETCH_CYC = DEF_PREFETCH_CYC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [11:0] x,
  output logic [10:0] y,
  output logic        active,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic        line_req,
  output logic [10:0] line_req_y,
  input  logic        line_ack,
  output logic        underrun
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] REQ_HC   = HW'(H_TOTAL - PREFETCH_CYC);
  localparam logic [VW-1:0] V_ACT_LIM = VW'(V_ACTIVE);

  logic [HW-1:0] w_hc;
  logic [VW-1:0] w_vc;
  logic          w_h_last, w_v_last;
  logic          w_h_wrap;
  logic          w_hsync_lvl, w_vsync_lvl;
  logic          w_h_act, w_v_act, w_act;
  logic [VW-1:0] w_vc_next;
  logic          w_req_slot;

  logic [11:0]   r_x;
  logic [10:0]   r_y;
  logic          r_active, r_hsync, r_vsync, r_frame_start;
  logic          r_line_req, r_underrun;
  logic [10:0]   r_line_req_y;

  assign w_h_wrap = enable & w_h_last;

  raster_axis_cnt #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HS_POL)
  ) u_h_axis (
    .clk      (clk),
    .reset    (reset),
    .i_inc    (enable),
    .o_count  (w_hc),
    .o_last   (w_h_last),
    .o_sync   (w_hsync_lvl),
    .o_active (w_h_act)
  );

  raster_axis_cnt #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VS_POL)
  ) u_v_axis (
    .clk      (clk),
    .reset    (reset),
    .i_inc    (w_h_wrap),
    .o_count  (w_vc),
    .o_last   (w_v_last),
    .o_sync   (w_vsync_lvl),
    .o_active (w_v_act)
  );

  assign w_act = w_h_act & w_v_act;

  // Row that starts after the current line, modulo the frame.
  assign w_vc_next  = w_v_last ? '0 : w_vc + VW'(1);
  assign w_req_slot = enable && (w_hc == REQ_HC) && (w_vc_next < V_ACT_LIM);

  // Registered raster outputs: one clock behind the counters, frozen by enable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_x           <= '0;
      r_y           <= '0;
      r_active      <= 1'b0;
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_frame_start <= 1'b0;
    end else if (enable) begin
      r_x           <= w_act ? 12'(w_hc) : 12'd0;
      r_y           <= w_act ? 11'(w_vc) : 11'd0;
      r_active      <= w_act;
      r_hsync       <= w_hsync_lvl;
      r_vsync       <= w_vsync_lvl;
      r_frame_start <= (w_hc == '0) && (w_vc == '0);
    end
  end

  // Fetch request. An acknowledge always completes the handshake, even while
  // frozen, and beats the deadline when both land on the same clock. The
  // deadline is the horizontal wrap that begins the requested line; the
  // request window never spans more than one wrap, so any wrap with a
  // pending request is that request's deadline. A new slot overrides last.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_line_req   <= 1'b0;
      r_line_req_y <= '0;
      r_underrun   <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      if (r_line_req && line_ack) begin
        r_line_req <= 1'b0;
      end else if (r_line_req && w_h_wrap) begin
        r_line_req <= 1'b0;
        r_underrun <= 1'b1;
      end
      if (w_req_slot) begin
        r_line_req   <= 1'b1;
        r_line_req_y <= 11'(w_vc_next);
      end
    end
  end

  assign x           = r_x;
  assign y           = r_y;
  assign active      = r_active;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign frame_start = r_frame_start;
  assign line_req    = r_line_req;
  assign line_req_y  = r_line_req_y;
  assign underrun    = r_underrun;

endmodule

// File: tb/tb_scan_timing_ctrl.sv
module tb_scan_timing_ctrl;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int PF = 3;
  localparam bit HP = 1'b1, VP = 1'b1;
  localparam int HT = HA + HF + HS + HB;   // 14
  localparam int VT = VA + VF + VS + VB;   // 7
  localparam int FT = HT * VT;             // 98

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        line_ack = 1'b0;
  logic [11:0] x;
  logic [10:0] y;
  logic        active, hsync, vsync, frame_start, line_req, underrun;
  logic [10:0] line_req_y;

  scan_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(HP), .VS_POL(VP), .PREFETCH_CYC(PF)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .x(x), .y(y), .active(active), .hsync(hsync), .vsync(vsync),
    .frame_start(frame_start), .line_req(line_req), .line_req_y(line_req_y),
    .line_ack(line_ack), .underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] x;
    logic [10:0] y;
    logic        act;
    logic        hs;
    logic        vs;
    logic        fs;
    logic        req;
    logic [10:0] ry;
    logic        und;
  } obs_t;

  // Reference model: raster position as a single frame offset, request as a flag.
  obs_t exp_o;
  int   pos = 0;
  bit   m_pend = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  logic d1 = 1'b0, d2 = 1'b0;   // line_req delay line for the tied-ack reader

  function automatic obs_t observe();
    obs_t o;
    o.x = x; o.y = y; o.act = active; o.hs = hsync; o.vs = vsync;
    o.fs = frame_start; o.req = line_req; o.ry = line_req_y; o.und = underrun;
    return o;
  endfunction

  // Drive one clock of inputs, advance the model across the edge, settle.
  task automatic tick(input logic rst_n, input logic en, input logic ack);
    int h, v;
    bit in_act;
    reset = rst_n; enable = en; line_ack = ack;
    @(posedge clk);
    h = pos % HT;
    v = pos / HT;
    if (!rst_n) begin
      pos    = 0;
      m_pend = 1'b0;
      exp_o  = '0;
      exp_o.hs = ~HP;
      exp_o.vs = ~VP;
    end else begin
      exp_o.und = 1'b0;
      if (m_pend && ack) begin
        m_pend = 1'b0;
        $display("txn t=%0t: row %0d fetch accepted", $time, exp_o.ry);
      end else if (m_pend && en && h == HT - 1) begin
        m_pend = 1'b0;
        exp_o.und = 1'b1;
        $display("txn t=%0t: row %0d fetch late, underrun", $time, exp_o.ry);
      end
      if (en && h == HT - PF && ((v + 1) % VT) < VA) begin
        m_pend   = 1'b1;
        exp_o.ry = 11'((v + 1) % VT);
      end
      exp_o.req = m_pend;
      if (en) begin
        in_act    = (h < HA) && (v < VA);
        exp_o.act = in_act;
        exp_o.x   = in_act ? 12'(h) : 12'd0;
        exp_o.y   = in_act ? 11'(v) : 11'd0;
        exp_o.hs  = (h >= HA + HF && h < HA + HF + HS) ? HP : ~HP;
        exp_o.vs  = (v >= VA + VF && v < VA + VF + VS) ? VP : ~VP;
        exp_o.fs  = (pos == 0);
        pos = (pos + 1) % FT;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    int hs_cnt = 0, act_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 1'b0);
      vectors++;
      if (observe() !== exp_o) begin
        miscompares++;
        $display("FAIL reset_state: got=%h expected=%h", observe(), exp_o);
      end
    end
    for (int i = 0; i < HT; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      vectors++;
      if (observe() !== exp_o) begin
        miscompares++;
        $display("FAIL first_line t=%0t: got=%h expected=%h", $time, observe(), exp_o);
      end
      if (i == 0) begin
        vectors++;
        if ({frame_start, active, x, y} !== {1'b1, 1'b1, 12'd0, 11'd0}) begin
          miscompares++;
          $display("FAIL first_pixel: got fs=%b act=%b x=%0d y=%0d expected fs=1 act=1 x=0 y=0",
                   frame_start, active, x, y);
        end
      end
      hs_cnt  += int'(hsync);
      act_cnt += int'(active);
    end
    vectors++;
    if (hs_cnt != HS || act_cnt != HA) begin
      miscompares++;
      $display("FAIL line_widths: got hsync=%0d active=%0d expected hsync=%0d active=%0d",
               hs_cnt, act_cnt, HS, HA);
    end
  endtask

  task automatic test_frames();
    int vs_cnt = 0, fs_cnt = 0, und_cnt = 0, last_fs = -1, gap = 0;
    d1 = 1'b0; d2 = 1'b0;
    for (int i = 0; i < 2 * FT; i++) begin
      tick(1'b1, 1'b1, d2);
      d2 = d1; d1 = line_req;
      vectors++;
      if (observe() !== exp_o) begin
        miscompares++;
        $display("FAIL frames t=%0t: got=%h expected=%h", $time, observe(), exp_o);
      end
      vs_cnt  += int'(vsync);
      und_cnt += int'(underrun);
      if (frame_start) begin
        fs_cnt++;
        if (last_fs >= 0) gap = i - last_fs;
        last_fs = i;
      end
    end
    vectors++;
    if (vs_cnt != 2 * VS * HT || fs_cnt != 2 || gap != FT || und_cnt != 0) begin
      miscompares++;
      $display("FAIL frame_stats: got vsync=%0d fs=%0d gap=%0d und=%0d expected %0d 2 %0d 0",
               vs_cnt, fs_cnt, gap, und_cnt, 2 * VS * HT, FT);
    end
  endtask

  task automatic test_handshake();
    int rises = 0, row_sum = 0, und_cnt = 0;
    logic prev;
    d1 = 1'b0; d2 = 1'b0;
    prev = line_req;
    for (int i = 0; i < FT; i++) begin
      tick(1'b1, 1'b1, d2);
      d2 = d1; d1 = line_req;
      vectors++;
      if (observe() !== exp_o) begin
        miscompares++;
        $display("FAIL handshake t=%0t: got=%h expected=%h", $time, observe(), exp_o);
      end
      if (line_req && !prev) begin
        rises++;
        row_sum += int'(line_req_y);
      end
      prev = line_req;
      und_cnt += int'(underrun);
    end
    vectors++;
    if (rises != VA || row_sum != 6 || und_cnt != 0) begin
      miscompares++;
      $display("FAIL handshake_stats: got reqs=%0d rowsum=%0d und=%0d expected 4 6 0",
               rises, row_sum, und_cnt);
    end
  endtask

  task automatic test_underrun();
    int und_cnt = 0, rises = 0;
    logic prev;
    prev = line_req;
    for (int i = 0; i < FT; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      vectors++;
      if (observe() !== exp_o) begin
        miscompares++;
        $display("FAIL underrun t=%0t: got=%h expected=%h", $time, observe(), exp_o);
      end
      if (line_req && !prev) rises++;
      prev = line_req;
      und_cnt += int'(underrun);
    end
    vectors++;
    if (und_cnt != VA || rises != VA) begin
      miscompares++;
      $display("FAIL underrun_stats: got und=%0d reqs=%0d expected 4 4", und_cnt, rises);
    end
  endtask

  task automatic test_deadline_and_freeze();
    int   und_cnt = 0;
    int   tgt_h;
    bit   found;
    obs_t held;
    logic ack;
    for (int i = 0; i < FT; i++) begin
      ack = (m_pend && (pos % HT) == HT - 1);
      tick(1'b1, 1'b1, ack);
      vectors++;
      if (observe() !== exp_o) begin
        miscompares++;
        $display("FAIL deadline_ack t=%0t: got=%h expected=%h", $time, observe(), exp_o);
      end
      und_cnt += int'(underrun);
    end
    vectors++;
    if (und_cnt != 0) begin
      miscompares++;
      $display("FAIL deadline_ack_stats: got und=%0d expected 0", und_cnt);
    end
    for (int k = 0; k < 2; k++) begin
      tgt_h = (k == 0) ? 5 : 12;
      found = 1'b0;
      for (int i = 0; i < FT && !found; i++) begin
        if ((pos % HT) == tgt_h && (pos / HT) == 1) begin
          found = 1'b1;
        end else begin
          ack = (m_pend && (pos % HT) == HT - 1);
          tick(1'b1, 1'b1, ack);
          vectors++;
          if (observe() !== exp_o) begin
            miscompares++;
            $display("FAIL freeze_seek t=%0t: got=%h expected=%h", $time, observe(), exp_o);
          end
        end
      end
      vectors++;
      if (!found) begin
        miscompares++;
        $display("FAIL freeze_seek_timeout: got no h=%0d v=1 within budget, expected found", tgt_h);
      end
      held = exp_o;
      for (int i = 0; i < 20; i++) begin
        tick(1'b1, 1'b0, 1'b0);
        vectors++;
        if (observe() !== exp_o || {x, y, line_req, line_req_y} !== {held.x, held.y, held.req, held.ry}) begin
          miscompares++;
          $display("FAIL freeze t=%0t: got=%h expected=%h", $time, observe(), held);
        end
      end
      for (int i = 0; i < 30; i++) begin
        ack = (m_pend && (pos % HT) == HT - 1);
        tick(1'b1, 1'b1, ack);
        vectors++;
        if (observe() !== exp_o || underrun !== 1'b0) begin
          miscompares++;
          $display("FAIL resume t=%0t: got=%h expected=%h", $time, observe(), exp_o);
        end
      end
    end
  endtask

  task automatic test_reset_midreq();
    bit found = 1'b0;
    int und_cnt = 0;
    for (int i = 0; i < 2 * FT && !found; i++) begin
      if (exp_o.req && (pos / HT) == 2) begin
        found = 1'b1;
      end else begin
        tick(1'b1, 1'b1, 1'b0);
        vectors++;
        if (observe() !== exp_o) begin
          miscompares++;
          $display("FAIL midreq_seek t=%0t: got=%h expected=%h", $time, observe(), exp_o);
        end
      end
    end
    vectors++;
    if (!found || line_req !== 1'b1) begin
      miscompares++;
      $display("FAIL midreq_setup: got found=%0d req=%b expected found=1 req=1", found, line_req);
    end
    tick(1'b0, 1'b1, 1'b0);
    vectors++;
    if (observe() !== exp_o || {line_req, underrun, x, y} !== 25'd0) begin
      miscompares++;
      $display("FAIL midreq_reset: got=%h expected=%h", observe(), exp_o);
    end
    tick(1'b1, 1'b1, 1'b0);
    vectors++;
    if (observe() !== exp_o || frame_start !== 1'b1) begin
      miscompares++;
      $display("FAIL midreq_restart: got=%h expected=%h", observe(), exp_o);
    end
    d1 = 1'b0; d2 = 1'b0;
    for (int i = 0; i < FT; i++) begin
      tick(1'b1, 1'b1, d2);
      d2 = d1; d1 = line_req;
      vectors++;
      if (observe() !== exp_o) begin
        miscompares++;
        $display("FAIL midreq_frame t=%0t: got=%h expected=%h", $time, observe(), exp_o);
      end
      und_cnt += int'(underrun);
    end
    vectors++;
    if (und_cnt != 0) begin
      miscompares++;
      $display("FAIL midreq_frame_stats: got und=%0d expected 0", und_cnt);
    end
  endtask

  task automatic test_random();
    logic r, e, a;
    for (int i = 0; i < 800; i++) begin
      r = ($urandom_range(0, 249) != 0);
      e = ($urandom_range(0, 7) != 0);
      a = ($urandom_range(0, 2) == 0);
      tick(r, e, a);
      vectors++;
      if (observe() !== exp_o) begin
        miscompares++;
        $display("FAIL random t=%0t rst_n=%b en=%b ack=%b: got=%h expected=%h",
                 $time, r, e, a, observe(), exp_o);
      end
    end
  endtask

  initial begin
    exp_o = '0;
    test_reset();
    test_frames();
    test_handshake();
    test_underrun();
    test_deadline_and_freeze();
    test_reset_midreq();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
